// File: rtl/gpr_snap_pkg.sv
// -----------------------------------------------------------------------------
// gpr_snap_pkg
// Shared definitions for the GPR snapshot controller: FSM state encoding,
// default sizing constants and the fixed width of the register-file and
// trace-sink index ports.
// -----------------------------------------------------------------------------
package gpr_snap_pkg;

  localparam int XLEN_DEF         = 64;
  localparam int NREG_DEF         = 32;
  localparam int STARVE_LIMIT_DEF = 8;
  localparam int IDX_W_DEF        = $clog2(NREG_DEF);

  // rf_raddr / out_idx are always 5 bits wide, whatever NREG is.
  localparam int PORT_IDX_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_SEND  = 2'd3
  } snap_state_e;

endpackage : gpr_snap_pkg

// File: rtl/gpr_starve_cnt.sv
// -----------------------------------------------------------------------------
// gpr_starve_cnt
// Counts consecutive cycles in which the snapshot lost the read port to the
// pipeline. Once the count reaches LIMIT, pipe_stall is raised while the
// snapshot is asking for the port, forcing one grant to the snapshot.
//
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   active       : snapshot is requesting the read port this cycle
//   clr          : clear the count (grant taken or snapshot aborted)
//   inc          : snapshot was denied this cycle (saturating increment)
//   pipe_stall   : force the pipeline off the read port
// -----------------------------------------------------------------------------
module gpr_starve_cnt
  import gpr_snap_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic clr,
  input  logic inc,
  output logic pipe_stall
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          limit_hit;

  assign limit_hit = (cnt_q == CW'(LIMIT));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !limit_hit) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign pipe_stall = active && limit_hit;

endmodule : gpr_starve_cnt

// File: rtl/gpr_snapshot_ctrl.sv
// -----------------------------------------------------------------------------
// gpr_snapshot_ctrl
// Walks x0..x(NREG-1) through the register file's shared read port and streams
// each value, tagged with the committing PC, to the difftest/trace sink.
// The pipeline owns the read port by default; the starvation counter forces a
// single grant to the snapshot after STARVE_LIMIT consecutive denials.
//
// Ports:
//   clock, reset        : system clock, asynchronous active-high reset
//   snap_req_*          : snapshot request from commit (valid/ready + PC tag)
//   flush               : abort the snapshot in progress
//   pipe_rd_en          : pipeline wants the read port
//   pipe_stall          : pipeline must back off this cycle
//   rf_ren/raddr/rdata  : register-file read port (data one cycle after ren)
//   out_*               : beat stream to the sink (valid/ready handshake)
//   busy                : controller is not idle
// -----------------------------------------------------------------------------
module gpr_snapshot_ctrl
  import gpr_snap_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int NREG         = NREG_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  snap_req_valid,
  output logic                  snap_req_ready,
  input  logic [XLEN-1:0]       snap_req_pc,
  input  logic                  flush,
  input  logic                  pipe_rd_en,
  output logic                  pipe_stall,
  output logic                  rf_ren,
  output logic [PORT_IDX_W-1:0] rf_raddr,
  input  logic [XLEN-1:0]       rf_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PORT_IDX_W-1:0] out_idx,
  output logic [XLEN-1:0]       out_data,
  output logic [XLEN-1:0]       out_pc,
  output logic                  out_last,
  output logic                  busy
);

  localparam int IDX_W = $clog2(NREG);

  snap_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  data_q, data_d;

  logic in_issue, in_send, grant, is_last, flush_act;

  assign in_issue  = (state_q == S_ISSUE);
  assign in_send   = (state_q == S_SEND);
  assign is_last   = (idx_q == IDX_W'(NREG - 1));
  // flush only means something while a snapshot is in flight.
  assign flush_act = flush && (state_q != S_IDLE);
  // The snapshot wins the port when the pipeline is quiet or is being stalled.
  assign grant     = !pipe_rd_en || pipe_stall;

  gpr_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clock      (clock),
    .reset      (reset),
    .active     (in_issue),
    .clr        (flush_act || (in_issue && grant)),
    .inc        (in_issue && !grant),
    .pipe_stall (pipe_stall)
  );

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pc_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pc_d    = pc_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        // snap_req_ready is 1 throughout IDLE, so valid alone is the handshake.
        if (snap_req_valid) begin
          pc_d    = snap_req_pc;
          idx_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (grant) state_d = S_WAIT;
      end
      S_WAIT: begin
        // x0 is hardwired to zero regardless of what the read port returns.
        data_d  = (idx_q == '0) ? '0 : rf_rdata;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          if (is_last) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides every other transition.
    if (flush_act) state_d = S_IDLE;
  end

  // Outputs. Beat fields are zero outside SEND so the sink never sees stale data.
  always_comb begin
    snap_req_ready = (state_q == S_IDLE);
    busy           = (state_q != S_IDLE);
    rf_ren         = in_issue && grant;
    rf_raddr       = rf_ren ? PORT_IDX_W'(idx_q) : '0;
    out_valid      = in_send;
    out_idx        = in_send ? PORT_IDX_W'(idx_q) : '0;
    out_data       = in_send ? data_q : '0;
    out_pc         = in_send ? pc_q : '0;
    out_last       = in_send && is_last;
  end

endmodule : gpr_snapshot_ctrl

// File: tb/tb_gpr_snapshot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpr_snapshot_ctrl
// Directed bench: a cycle table for the start of a snapshot, request/flush
// corners, then whole-snapshot sequences (plain, starved, backpressured,
// flushed, reset mid-WAIT, back-to-back requests) against a register-file
// model preloaded with i*0x1111 (x0 holds junk that must be masked).
// -----------------------------------------------------------------------------
module tb_gpr_snapshot_ctrl;
  import gpr_snap_pkg::*;

  localparam int XLEN   = 64;
  localparam int NREG   = 32;
  localparam int STARVE = 8;

  logic            clock, reset;
  logic            snap_req_valid, snap_req_ready;
  logic [XLEN-1:0] snap_req_pc;
  logic            flush, pipe_rd_en, pipe_stall;
  logic            rf_ren;
  logic [4:0]      rf_raddr;
  logic [XLEN-1:0] rf_rdata;
  logic            out_valid, out_ready, out_last, busy;
  logic [4:0]      out_idx;
  logic [XLEN-1:0] out_data, out_pc;

  gpr_snapshot_ctrl #(
    .XLEN(XLEN), .NREG(NREG), .STARVE_LIMIT(STARVE)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .snap_req_valid (snap_req_valid),
    .snap_req_ready (snap_req_ready),
    .snap_req_pc    (snap_req_pc),
    .flush          (flush),
    .pipe_rd_en     (pipe_rd_en),
    .pipe_stall     (pipe_stall),
    .rf_ren         (rf_ren),
    .rf_raddr       (rf_raddr),
    .rf_rdata       (rf_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_idx        (out_idx),
    .out_data       (out_data),
    .out_pc         (out_pc),
    .out_last       (out_last),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register-file model: data one cycle after ren, junk otherwise.
  logic [XLEN-1:0] mem [NREG];
  always @(posedge clock)
    rf_rdata <= rf_ren ? mem[rf_raddr] : 64'hBAD0_BAD0_BAD0_BAD0;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_data(input int i);
    return (i == 0) ? '0 : XLEN'(i) * 64'h1111;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, snap_req_ready, 1);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_ov"},    out_valid, 0);
  endtask

  // Runs one snapshot starting with the accept cycle. Expected timing: after
  // accept/handshake the grant comes on cycle gnt (1, or STARVE+1 when the
  // pipeline holds the port) and the beat appears two cycles later.
  task automatic run_scan(input logic [XLEN-1:0] pc, input bit pbusy,
                          input int hold_idx, input int hold_len, input bit keep_req);
    int  beat = 0, since = 0, cyc = 0, held = 0, first = -1;
    int  gnt = pbusy ? STARVE + 1 : 1;
    bit  done = 0;
    @(negedge clock);
    snap_req_valid = 1'b1; snap_req_pc = pc; pipe_rd_en = pbusy; out_ready = 1'b1;
    #1 check("accept_ready", snap_req_ready, 1);
    while (!done && cyc < 2000) begin
      @(negedge clock);
      snap_req_valid = keep_req;
      snap_req_pc    = ~pc;           // must not be relatched mid-scan
      cyc++; since++;
      #1;
      check("scan_busy",  busy, 1);
      check("scan_ready", snap_req_ready, 0);
      check("scan_ren",   rf_ren, since == gnt);
      check("scan_stall", pipe_stall, pbusy && since == gnt);
      if (rf_ren) check("scan_raddr", rf_raddr, beat);
      check("scan_ov", out_valid, since >= gnt + 2);
      if (out_valid) begin
        if (first < 0) first = cyc;
        check("beat_idx",  out_idx, beat);
        check("beat_data", out_data, exp_data(beat));
        check("beat_pc",   out_pc, pc);
        check("beat_last", out_last, beat == NREG - 1);
        if (beat == hold_idx && held < hold_len) begin
          out_ready = 1'b0;
          held++;
        end else begin
          out_ready = 1'b1;
          beat++; since = 0;
          if (beat == NREG) done = 1;
        end
      end
    end
    check("scan_done",    done, 1);
    check("first_beat",   first, gnt + 2);
    check("scan_cycles",  cyc, NREG * (gnt + 2) + hold_len);
    out_ready = 1'b1;
  endtask

  typedef struct {
    logic req; logic [XLEN-1:0] pc; logic prd, ordy, fl;
    logic e_rdy, e_busy, e_ren, e_stall, e_ov, e_last;
    logic [4:0] e_raddr, e_idx;
    logic [XLEN-1:0] e_data, e_pc;
  } vec_t;

  vec_t vecs[15];

  initial begin
    for (int i = 0; i < NREG; i++) mem[i] = exp_data(i);
    mem[0] = 64'hDEAD_BEEF;           // x0 must read back as zero anyway

    reset = 1'b1; snap_req_valid = 0; snap_req_pc = '0; flush = 0;
    pipe_rd_en = 0; out_ready = 1;
    repeat (2) @(negedge clock);
    #1;
    check("rst_ready", snap_req_ready, 1);
    check("rst_busy",  busy, 0);
    check("rst_ren",   rf_ren, 0);
    check("rst_raddr", rf_raddr, 0);
    check("rst_stall", pipe_stall, 0);
    check("rst_ov",    out_valid, 0);
    check("rst_idx",   out_idx, 0);
    check("rst_data",  out_data, 0);
    check("rst_pc",    out_pc, 0);
    check("rst_last",  out_last, 0);
    reset = 1'b0;

    //          req pc            prd ordy fl  rdy busy ren stl ov last raddr idx data     pc
    vecs[0]  = '{0, 64'h0,        0,  1,   0,  1,  0,   0,  0,  0, 0,   0,    0,  0,       0};
    vecs[1]  = '{1, 64'h80000000, 0,  1,   0,  1,  0,   0,  0,  0, 0,   0,    0,  0,       0};
    vecs[2]  = '{0, 64'h0,        1,  1,   0,  0,  1,   0,  0,  0, 0,   0,    0,  0,       0};
    vecs[3]  = '{0, 64'h0,        0,  1,   0,  0,  1,   1,  0,  0, 0,   0,    0,  0,       0};
    vecs[4]  = '{0, 64'h0,        0,  1,   0,  0,  1,   0,  0,  0, 0,   0,    0,  0,       0};
    vecs[5]  = '{0, 64'h0,        0,  0,   0,  0,  1,   0,  0,  1, 0,   0,    0,  0,       64'h80000000};
    vecs[6]  = '{0, 64'h0,        0,  1,   0,  0,  1,   0,  0,  1, 0,   0,    0,  0,       64'h80000000};
    vecs[7]  = '{0, 64'h0,        0,  1,   0,  0,  1,   1,  0,  0, 0,   1,    0,  0,       0};
    vecs[8]  = '{0, 64'h0,        0,  1,   0,  0,  1,   0,  0,  0, 0,   0,    0,  0,       0};
    vecs[9]  = '{0, 64'h0,        0,  1,   0,  0,  1,   0,  0,  1, 0,   0,    1,  64'h1111, 64'h80000000};
    vecs[10] = '{0, 64'h0,        1,  1,   1,  0,  1,   0,  0,  0, 0,   0,    0,  0,       0};
    vecs[11] = '{1, 64'h1234,     0,  1,   1,  1,  0,   0,  0,  0, 0,   0,    0,  0,       0};
    vecs[12] = '{0, 64'h0,        1,  1,   0,  0,  1,   0,  0,  0, 0,   0,    0,  0,       0};
    vecs[13] = '{0, 64'h0,        1,  1,   1,  0,  1,   0,  0,  0, 0,   0,    0,  0,       0};
    vecs[14] = '{0, 64'h0,        0,  1,   0,  1,  0,   0,  0,  0, 0,   0,    0,  0,       0};

    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      snap_req_valid = vecs[i].req; snap_req_pc = vecs[i].pc;
      pipe_rd_en = vecs[i].prd; out_ready = vecs[i].ordy; flush = vecs[i].fl;
      #1;
      check($sformatf("v%0d_ready", i), snap_req_ready, vecs[i].e_rdy);
      check($sformatf("v%0d_busy", i),  busy,           vecs[i].e_busy);
      check($sformatf("v%0d_ren", i),   rf_ren,         vecs[i].e_ren);
      check($sformatf("v%0d_stall", i), pipe_stall,     vecs[i].e_stall);
      check($sformatf("v%0d_ov", i),    out_valid,      vecs[i].e_ov);
      check($sformatf("v%0d_last", i),  out_last,       vecs[i].e_last);
      check($sformatf("v%0d_raddr", i), rf_raddr,       vecs[i].e_raddr);
      check($sformatf("v%0d_idx", i),   out_idx,        vecs[i].e_idx);
      check($sformatf("v%0d_data", i),  out_data,       vecs[i].e_data);
      check($sformatf("v%0d_pc", i),    out_pc,         vecs[i].e_pc);
    end
    @(negedge clock);
    snap_req_valid = 0; flush = 0; pipe_rd_en = 0; out_ready = 1;

    // Starvation right after a flush from ISSUE: exactly 8 denials per register.
    run_scan(64'h4000_0000, 1'b1, -1, 0, 1'b0);
    @(negedge clock); snap_req_valid = 0; pipe_rd_en = 0;
    #1 check_idle("starve_end");

    // Basic scan: 96 cycles, idle on cycle 97.
    run_scan(64'h8000_0000, 1'b0, -1, 0, 1'b0);
    @(negedge clock); snap_req_valid = 0;
    #1 check_idle("basic_end");

    // Sink backpressure: beat 7 held for 5 cycles.
    run_scan(64'h8000_0100, 1'b0, 7, 5, 1'b0);
    @(negedge clock); snap_req_valid = 0;
    #1 check_idle("bp_end");

    // Flush while beat 12 is in SEND (with out_ready high), then restart.
    begin
      bit found = 0;
      @(negedge clock); snap_req_valid = 1; snap_req_pc = 64'hAAAA_0000;
      for (int k = 0; k < 200 && !found; k++) begin
        @(negedge clock); snap_req_valid = 0;
        #1;
        if (out_valid && out_idx == 12) begin
          flush = 1'b1;
          found = 1;
        end
      end
      check("flush_reach_idx12", found, 1);
      @(negedge clock); flush = 1'b0;
      #1 check_idle("flush");
      run_scan(64'hBBBB_0000, 1'b0, -1, 0, 1'b0);
      @(negedge clock); snap_req_valid = 0;
      #1 check_idle("flush_restart_end");
    end

    // Asynchronous reset in the middle of WAIT.
    @(negedge clock); snap_req_valid = 1; snap_req_pc = 64'hCCCC_0000;
    @(negedge clock); snap_req_valid = 0;        // ISSUE
    @(negedge clock);                            // WAIT
    #1;
    check("wait_busy", busy, 1);
    check("wait_ov",   out_valid, 0);
    #1 reset = 1'b1;
    #1;
    check_idle("async_rst");
    check("async_rst_ren", rf_ren, 0);
    check("async_rst_idx", out_idx, 0);
    @(negedge clock); reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock); #1;
      check("post_rst_ov",   out_valid, 0);
      check("post_rst_busy", busy, 0);
    end

    // Request held high through a scan; second one accepted right after.
    run_scan(64'h1111_0000, 1'b0, -1, 0, 1'b1);
    run_scan(64'h2222_0000, 1'b0, -1, 0, 1'b0);
    @(negedge clock); snap_req_valid = 0;
    #1 check_idle("b2b_end");

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_gpr_snapshot_ctrl
